// File: rtl/av_bus_pkg.sv
// Shared definitions for the two-master Avalon-style bus arbiter.
package av_bus_pkg;

    typedef enum logic {
        M_IBUS = 1'b0,
        M_DBUS = 1'b1
    } master_e;

    localparam int          RD_LAT      = 1;
    localparam logic [31:0] RD_UNMAPPED = 32'h0;

endpackage

// File: rtl/av_addr_decode.sv
// Slave index decode: one-hot select plus an unmapped flag for indices past the last slave.
module av_addr_decode #(
    parameter int ADDR_SEL_BITS = 6,
    parameter int NUM_SLAVES    = 4
) (
    input  logic [ADDR_SEL_BITS-1:0] index_i,
    output logic [NUM_SLAVES-1:0]    sel_o,
    output logic                     unmapped_o
);

    always_comb begin
        // NOTE: default assigned first so every path drives sel_o and no latch is inferred.
        sel_o = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (index_i == ADDR_SEL_BITS'(k)) sel_o[k] = 1'b1;
        end
    end

    assign unmapped_o = ~|sel_o;

endmodule

// File: rtl/av_bus_arbiter.sv
// Round-robin arbiter between instruction (M0) and data (M1) masters driving a shared
// slave bus, with address decode and single-cycle read-data return routing.
module av_bus_arbiter
    import av_bus_pkg::*;
#(
    parameter int ADDR_SEL_BITS = 6,
    parameter int NUM_SLAVES    = 4
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst_n,
    input  logic [31:0]                i_M0_Addr,
    input  logic                       i_M0_Read,
    output logic [31:0]                o_M0_ReadData,
    output logic                       o_M0_ReadDataValid,
    output logic                       o_M0_WaitRequest,
    input  logic [31:0]                i_M1_Addr,
    input  logic [3:0]                 i_M1_ByteEn,
    input  logic                       i_M1_Read,
    input  logic                       i_M1_Write,
    input  logic [31:0]                i_M1_WriteData,
    output logic [31:0]                o_M1_ReadData,
    output logic                       o_M1_ReadDataValid,
    output logic                       o_M1_WaitRequest,
    output logic [NUM_SLAVES-1:0]      o_S_Sel,
    output logic [29-ADDR_SEL_BITS:0]  o_S_RegAddr,
    output logic [3:0]                 o_S_ByteEn,
    output logic                       o_S_Read,
    output logic                       o_S_Write,
    output logic [31:0]                o_S_WriteData,
    input  logic [32*NUM_SLAVES-1:0]   i_S_ReadData,
    input  logic [NUM_SLAVES-1:0]      i_S_WaitRequest,
    output logic                       o_BusError
);

    logic                     req0, req1, gnt_valid, is_wr, accept, slv_wait, unmapped;
    master_e                  gnt_m;
    logic [31:0]              sel_addr, rd_data;
    logic [ADDR_SEL_BITS-1:0] index;
    logic [NUM_SLAVES-1:0]    sel;
    logic                     unused_addr_bits;

    master_e                  last_q, last_d, hold_m_q, hold_m_d, rd_m_q, rd_m_d;
    logic                     hold_q, hold_d, rd_valid_q, rd_valid_d;
    logic                     rd_unm_q, rd_unm_d, bus_err_q, bus_err_d;
    logic [ADDR_SEL_BITS-1:0] rd_idx_q, rd_idx_d;

    assign req0 = i_M0_Read;
    assign req1 = i_M1_Read | i_M1_Write;

    // A stalled transfer keeps its grant even if the round-robin pointer would now favour the other master.
    always_comb begin
        gnt_valid = req0 | req1;
        gnt_m     = M_IBUS;
        if (hold_q && ((hold_m_q == M_DBUS) ? req1 : req0)) gnt_m = hold_m_q;
        else if (req0 && req1) gnt_m = (last_q == M_DBUS) ? M_IBUS : M_DBUS;
        else if (req1)         gnt_m = M_DBUS;
    end

    assign sel_addr         = (gnt_m == M_DBUS) ? i_M1_Addr : i_M0_Addr;
    assign index            = sel_addr[31 -: ADDR_SEL_BITS];
    assign is_wr            = gnt_valid && (gnt_m == M_DBUS) && i_M1_Write;
    assign unused_addr_bits = ^sel_addr[1:0];

    av_addr_decode #(
        .ADDR_SEL_BITS (ADDR_SEL_BITS),
        .NUM_SLAVES    (NUM_SLAVES)
    ) u_decode (
        .index_i    (index),
        .sel_o      (sel),
        .unmapped_o (unmapped)
    );

    assign slv_wait = |(sel & i_S_WaitRequest);
    assign accept   = gnt_valid && (unmapped || !slv_wait);

    always_comb begin
        o_S_Sel       = '0;
        o_S_RegAddr   = '0;
        o_S_ByteEn    = '0;
        o_S_Read      = 1'b0;
        o_S_Write     = 1'b0;
        o_S_WriteData = '0;
        if (gnt_valid) begin
            o_S_Sel       = sel;
            o_S_RegAddr   = sel_addr[31-ADDR_SEL_BITS:2];
            o_S_ByteEn    = (gnt_m == M_DBUS) ? i_M1_ByteEn : 4'hF;
            o_S_Read      = !is_wr && !unmapped;
            o_S_Write     = is_wr && !unmapped;
            o_S_WriteData = (gnt_m == M_DBUS) ? i_M1_WriteData : '0;
        end
    end

    assign o_M0_WaitRequest = req0 && !(gnt_m == M_IBUS && accept);
    assign o_M1_WaitRequest = req1 && !(gnt_m == M_DBUS && accept);

    always_comb begin
        last_d     = accept ? gnt_m : last_q;
        hold_d     = gnt_valid && !accept;
        hold_m_d   = gnt_m;
        rd_valid_d = accept && !is_wr;
        rd_m_d     = gnt_m;
        rd_idx_d   = index;
        rd_unm_d   = unmapped;
        bus_err_d  = accept && unmapped;
    end

    always_ff @(posedge i_Clk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values.
        if (!i_Rst_n) begin
            last_q     <= M_DBUS;
            hold_q     <= 1'b0;
            hold_m_q   <= M_IBUS;
            rd_valid_q <= 1'b0;
            rd_m_q     <= M_IBUS;
            rd_idx_q   <= '0;
            rd_unm_q   <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            last_q     <= last_d;
            hold_q     <= hold_d;
            hold_m_q   <= hold_m_d;
            rd_valid_q <= rd_valid_d;
            rd_m_q     <= rd_m_d;
            rd_idx_q   <= rd_idx_d;
            rd_unm_q   <= rd_unm_d;
            bus_err_q  <= bus_err_d;
        end
    end

    always_comb begin
        rd_data = RD_UNMAPPED;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (!rd_unm_q && rd_idx_q == ADDR_SEL_BITS'(k)) rd_data = i_S_ReadData[32*k +: 32];
        end
    end

    // Return path is masked while reset is held so a read caught by reset never reports.
    assign o_M0_ReadDataValid = i_Rst_n && rd_valid_q && (rd_m_q == M_IBUS);
    assign o_M1_ReadDataValid = i_Rst_n && rd_valid_q && (rd_m_q == M_DBUS);
    assign o_M0_ReadData      = o_M0_ReadDataValid ? rd_data : '0;
    assign o_M1_ReadData      = o_M1_ReadDataValid ? rd_data : '0;
    assign o_BusError         = i_Rst_n && bus_err_q;

endmodule

// File: tb/tb_av_bus_arbiter.sv
// Directed bench for av_bus_arbiter: read returns are scoreboarded against expectations queued at acceptance.
module tb_av_bus_arbiter;
    import av_bus_pkg::*;

    localparam int ASB = 6;
    localparam int NS  = 4;

    typedef struct {
        master_e     m;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       m0_addr, m1_addr, m1_wdata;
    logic              m0_read, m1_read, m1_write;
    logic [3:0]        m1_be;
    logic [31:0]       m0_rdata, m1_rdata, s_wdata;
    logic              m0_rvalid, m1_rvalid, m0_wait, m1_wait;
    logic [NS-1:0]     s_sel, s_wait;
    logic [29-ASB:0]   s_regaddr;
    logic [3:0]        s_be;
    logic              s_read, s_write, bus_err;
    logic [32*NS-1:0]  s_rdata;

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc_cnt  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    av_bus_arbiter #(.ADDR_SEL_BITS(ASB), .NUM_SLAVES(NS)) dut (
        .i_Clk              (clk),
        .i_Rst_n            (rst_n),
        .i_M0_Addr          (m0_addr),
        .i_M0_Read          (m0_read),
        .o_M0_ReadData      (m0_rdata),
        .o_M0_ReadDataValid (m0_rvalid),
        .o_M0_WaitRequest   (m0_wait),
        .i_M1_Addr          (m1_addr),
        .i_M1_ByteEn        (m1_be),
        .i_M1_Read          (m1_read),
        .i_M1_Write         (m1_write),
        .i_M1_WriteData     (m1_wdata),
        .o_M1_ReadData      (m1_rdata),
        .o_M1_ReadDataValid (m1_rvalid),
        .o_M1_WaitRequest   (m1_wait),
        .o_S_Sel            (s_sel),
        .o_S_RegAddr        (s_regaddr),
        .o_S_ByteEn         (s_be),
        .o_S_Read           (s_read),
        .o_S_Write          (s_write),
        .o_S_WriteData      (s_wdata),
        .i_S_ReadData       (s_rdata),
        .i_S_WaitRequest    (s_wait),
        .o_BusError         (bus_err)
    );

    function automatic logic [31:0] slv_f(int k, logic [29-ASB:0] wa);
        return 32'h1234_567C ^ {8'h0, wa} ^ (32'(k) << 28);
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(master_e m, logic [31:0] data);
        exp_t e;
        e.m    = m;
        e.data = data;
        e.cyc  = cyc_cnt + RD_LAT;
        sb.push_back(e);
    endtask

    // Slave model: an accepted read on slave k returns slv_f(k, word address) in the next cycle.
    task automatic tick();
        logic [NS-1:0]   sel, wt;
        logic            rd;
        logic [29-ASB:0] wa;
        @(negedge clk);
        sel = s_sel;
        rd  = s_read;
        wa  = s_regaddr;
        wt  = s_wait;
        @(posedge clk);
        #1;
        for (int k = 0; k < NS; k++)
            s_rdata[32*k +: 32] = (rd && sel[k] && !wt[k]) ? slv_f(k, wa) : (32'hBAD0_0000 | 32'(k));
    endtask

    task automatic idle();
        m0_read  = 1'b0;
        m1_read  = 1'b0;
        m1_write = 1'b0;
        s_wait   = '0;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc < cyc_cnt) begin
            check("rd_missing_cyc", 64'(cyc_cnt), 64'(sb[0].cyc));
            void'(sb.pop_front());
        end
        if (m0_rvalid || m1_rvalid) begin
            n_checks++;
            assert (sb.size() > 0) else begin
                n_err++;
                $error("FAIL rd_unexpected: observed valid {m1,m0}=%b%b expected none", m1_rvalid, m0_rvalid);
            end
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("rd_master", {m1_rvalid, m0_rvalid}, (e.m == M_DBUS) ? 2'b10 : 2'b01);
                check("rd_data", (e.m == M_DBUS) ? m1_rdata : m0_rdata, e.data);
                check("rd_other_zero", (e.m == M_DBUS) ? m0_rdata : m1_rdata, 32'h0);
                check("rd_cyc", 64'(cyc_cnt), 64'(e.cyc));
            end
        end
    end

    initial begin
        logic [31:0] a0, a1;
        int          n0, n1;

        rst_n    = 1'b0;
        m0_addr  = '0;
        m1_addr  = '0;
        m1_be    = '0;
        m1_wdata = '0;
        s_rdata  = '0;
        idle();
        tick();
        tick();
        check("reset_outs", {m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, bus_err, s_sel, s_read, s_write},
              '0);
        check("reset_regaddr", s_regaddr, '0);
        rst_n = 1'b1;
        tick();

        // Single M0 read from slave 0.
        m0_read = 1'b1;
        m0_addr = 32'h0000_0010;
        #1;
        check("t1_sel", s_sel, 4'b0001);
        check("t1_regaddr", s_regaddr, 24'd4);
        check("t1_strobes", {s_read, s_write, s_be}, {1'b1, 1'b0, 4'hF});
        check("t1_wait", m0_wait, 1'b0);
        push(M_IBUS, 32'h1234_5678);
        tick();
        idle();
        #1;
        check("t1_rdata", {m0_rvalid, m0_rdata}, {1'b1, 32'h1234_5678});
        tick();
        check("t1_rvalid_pulse", {m0_rvalid, m1_rvalid}, 2'b00);

        // M1 write to slave 1.
        m1_write = 1'b1;
        m1_addr  = 32'h0400_0020;
        m1_be    = 4'b0101;
        m1_wdata = 32'hAABB_CCDD;
        #1;
        check("t3_sel", s_sel, 4'b0010);
        check("t3_strobes", {s_write, s_read, m1_wait}, 3'b100);
        check("t3_pass", {s_be, s_wdata, s_regaddr}, {4'b0101, 32'hAABB_CCDD, 24'd8});
        tick();
        // Read and write together: write wins.
        m1_read  = 1'b1;
        m1_wdata = 32'h0102_0304;
        #1;
        check("t3b_write_wins", {s_write, s_read, s_wdata}, {2'b10, 32'h0102_0304});
        tick();
        idle();

        // M1 read stalled three cycles by slave 2 while M0 joins.
        m1_read  = 1'b1;
        m1_addr  = 32'h0800_0040;
        s_wait   = 4'b0100;
        #1;
        check("t4_sel_a", s_sel, 4'b0100);
        check("t4_wait_a", m1_wait, 1'b1);
        tick();
        m0_read = 1'b1;
        m0_addr = 32'h0000_0030;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t4_hold_sel", s_sel, 4'b0100);
            check("t4_hold_wait", {m1_wait, m0_wait}, 2'b11);
            tick();
        end
        s_wait = '0;
        #1;
        check("t4_accept_sel", s_sel, 4'b0100);
        check("t4_accept_wait", {m1_wait, m0_wait}, 2'b01);
        push(M_DBUS, slv_f(2, 24'h10));
        tick();
        m1_read = 1'b0;
        #1;
        check("t4_m0_sel", s_sel, 4'b0001);
        check("t4_m0_wait", m0_wait, 1'b0);
        push(M_IBUS, slv_f(0, 24'hC));
        tick();
        idle();
        tick();

        // Unmapped index 63.
        m1_read = 1'b1;
        m1_addr = 32'hFC00_0000;
        #1;
        check("t5_sel", s_sel, 4'b0000);
        check("t5_wait_err", {m1_wait, bus_err}, 2'b00);
        push(M_DBUS, 32'h0);
        tick();
        idle();
        #1;
        check("t5_buserr", bus_err, 1'b1);
        tick();
        check("t5_buserr_pulse", bus_err, 1'b0);

        // Reset right after an accepted read discards it.
        m0_read = 1'b1;
        m0_addr = 32'h0000_0014;
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        check("t6_outs", {m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, bus_err, s_sel, s_read, s_write},
              '0);
        tick();
        rst_n = 1'b1;

        // Both masters read every cycle: grants alternate starting with M0.
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 4; i++) begin
            a0 = 32'h0000_0100 + 32'(n0 * 4);
            a1 = 32'h0C00_0200 + 32'(n1 * 4);
            m0_addr = a0;
            m1_addr = a1;
            m0_read = 1'b1;
            m1_read = 1'b1;
            #1;
            if (i % 2 == 0) begin
                check("rr_sel_m0", s_sel, 4'b0001);
                check("rr_wait_m0", {m1_wait, m0_wait}, 2'b10);
                push(M_IBUS, slv_f(0, a0[25:2]));
                n0++;
            end else begin
                check("rr_sel_m1", s_sel, 4'b1000);
                check("rr_wait_m1", {m1_wait, m0_wait}, 2'b01);
                push(M_DBUS, slv_f(3, a1[25:2]));
                n1++;
            end
            tick();
        end
        idle();
        tick();
        tick();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
